// File: rtl/instruction_fetch_register_pkg.sv
// Shared definitions for the multicycle-MIPS instruction fetch register:
// FSM encoding, MIPS field positions and the reset/flush NOP word.
package instruction_fetch_register_pkg;

  localparam int unsigned MIPS_WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_LOADED = 2'd2
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned JADDR_MSB  = 25;
  localparam int unsigned JADDR_LSB  = 0;

  // sll $0,$0,0
  localparam logic [MIPS_WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_register_if.sv
// Fetch handshake, memory bus and decoded-field bundle for the instruction register.
interface instruction_fetch_register_if #(
  parameter int unsigned WORD_LENGTH = 32
) ();

  logic                   fetch_start;
  logic                   flush;
  logic [WORD_LENGTH-1:0] mem_rdata;
  logic                   mem_ready;
  logic                   mem_req;
  logic [WORD_LENGTH-1:0] instr;
  logic [5:0]             opcode;
  logic [4:0]             rs;
  logic [4:0]             rt;
  logic [4:0]             rd;
  logic [4:0]             shamt;
  logic [5:0]             funct;
  logic [15:0]            imm16;
  logic [25:0]            jaddr;
  logic                   instr_valid;
  logic                   busy;
  logic                   timeout_err;

  // Control FSM / memory side
  modport master (
    output fetch_start, flush, mem_rdata, mem_ready,
    input  mem_req, instr, opcode, rs, rt, rd, shamt, funct, imm16, jaddr,
           instr_valid, busy, timeout_err
  );

  // Instruction register side
  modport slave (
    input  fetch_start, flush, mem_rdata, mem_ready,
    output mem_req, instr, opcode, rs, rt, rd, shamt, funct, imm16, jaddr,
           instr_valid, busy, timeout_err
  );

endinterface

// File: rtl/instruction_fetch_register_fetch_timeout_counter.sv
// Saturating wait counter for the REQ state; flags the last allowed cycle.
module fetch_timeout_counter
  import instruction_fetch_register_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal_c
);

  localparam int unsigned        CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_terminal;

  assign w_terminal   = (r_wait_cnt == CNT_LAST);
  assign o_terminal_c = w_terminal;

  // Holds at the terminal value rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (i_clear) begin
      r_wait_cnt <= '0;
    end else if (i_enable && !w_terminal) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch_register.sv
// Multicycle-MIPS instruction register: requests a word from memory, latches it
// on mem_ready, and holds it (with its decoded fields) until the next fetch.
module instruction_fetch_register
  import instruction_fetch_register_pkg::*;
#(
  parameter int unsigned             WORD_LENGTH    = 32,
  parameter int unsigned             TIMEOUT_CYCLES = 15,
  parameter logic [WORD_LENGTH-1:0]  RESET_INSTR    = WORD_LENGTH'(NOP_INSTR)
) (
  input  logic                          clk,
  input  logic                          reset,
  instruction_fetch_register_if.slave   bus
);

  fetch_state_e           r_state;
  fetch_state_e           w_state_nxt;
  logic [WORD_LENGTH-1:0] r_ir;
  logic                   r_timeout_err;

  logic w_ir_load;
  logic w_ir_clear;
  logic w_err_set;
  logic w_err_clr;
  logic w_cnt_clear;
  logic w_cnt_en;
  logic w_cnt_terminal;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fetch_timeout_counter (
    .clk          (clk),
    .rst_n        (reset),
    .i_clear      (w_cnt_clear),
    .i_enable     (w_cnt_en),
    .o_terminal_c (w_cnt_terminal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and datapath strobes; flush overrides every state
  always_comb begin
    w_state_nxt = r_state;
    w_ir_load   = 1'b0;
    w_ir_clear  = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    w_cnt_clear = (r_state != S_REQ);
    w_cnt_en    = 1'b0;

    case (r_state)
      S_IDLE, S_LOADED: begin
        if (bus.fetch_start) begin
          w_state_nxt = S_REQ;
          w_err_clr   = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.mem_ready) begin
          w_state_nxt = S_LOADED;
          w_ir_load   = 1'b1;
        end else if (w_cnt_terminal) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
        end else begin
          w_cnt_en    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_ir_load   = 1'b0;
      w_ir_clear  = 1'b1;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      w_cnt_clear = 1'b1;
      w_cnt_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ir <= RESET_INSTR;
    end else if (w_ir_clear) begin
      r_ir <= RESET_INSTR;
    end else if (w_ir_load) begin
      r_ir <= bus.mem_rdata;
    end
  end

  // Sticky until the next accepted fetch_start; flush leaves it alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_err_set) begin
      r_timeout_err <= 1'b1;
    end else if (w_err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign bus.mem_req     = (r_state == S_REQ);
  assign bus.busy        = (r_state == S_REQ);
  assign bus.instr_valid = (r_state == S_LOADED);
  assign bus.timeout_err = r_timeout_err;

  assign bus.instr  = r_ir;
  assign bus.opcode = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign bus.rs     = r_ir[RS_MSB:RS_LSB];
  assign bus.rt     = r_ir[RT_MSB:RT_LSB];
  assign bus.rd     = r_ir[RD_MSB:RD_LSB];
  assign bus.shamt  = r_ir[SHAMT_MSB:SHAMT_LSB];
  assign bus.funct  = r_ir[FUNCT_MSB:FUNCT_LSB];
  assign bus.imm16  = r_ir[IMM_MSB:IMM_LSB];
  assign bus.jaddr  = r_ir[JADDR_MSB:JADDR_LSB];

endmodule
